// File: rtl/lock_scheduler_pkg.sv
// ============================================================================
// | Module : lock_scheduler_pkg                                              |
// | Brief  : Shared types and constants for the canal lock scheduler:        |
// |          FSM state encoding, side codes, default waterway levels and a   |
// |          small integer helper used for counter sizing.                   |
// | Rev    : 1.0  initial release                                            |
// ============================================================================
`default_nettype none

package lock_scheduler_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_EQ_IN     = 4'd1,
      ST_OPEN_IN   = 4'd2,
      ST_ENTER     = 4'd3,
      ST_CLOSE_IN  = 4'd4,
      ST_EQ_OUT    = 4'd5,
      ST_OPEN_OUT  = 4'd6,
      ST_EXIT      = 4'd7,
      ST_CLOSE_OUT = 4'd8
   } state_t;

   // Side codes: the served side is the entry side, its complement the exit side.
   localparam logic SIDE_OUTER = 1'b0;
   localparam logic SIDE_INNER = 1'b1;

   localparam logic [7:0] DEF_OUTER_LEVEL = 8'd80;
   localparam logic [7:0] DEF_INNER_LEVEL = 8'd30;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lock_scheduler_gate.sv
// ============================================================================
// | Module : gate_timer                                                      |
// | Brief  : Loadable down-counter. A load presets the count; it then        |
// |          decrements to zero and holds. done is high while the count is   |
// |          zero, so a load of N-1 yields done on the N-th cycle after load.|
// | Ports  : clk, reset (async, active-high), load, load_val[W-1:0], done    |
// | Rev    : 1.0  initial release                                            |
// ============================================================================
`default_nettype none

module gate_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/lock_scheduler.sv
// ============================================================================
// | Module : lock_scheduler                                                  |
// | Brief  : Sequences one canal lock chamber between the outer and inner    |
// |          waterways: arbitrates passage requests, drives fill/drain to    |
// |          equalise, opens/closes ports with travel time, and never opens  |
// |          both ports together.                                            |
// | Ports  : clk, reset (async, active-high)                                 |
// |          req_outer/req_inner   held requests from each side              |
// |          gondola_in/_out       1-cycle chamber entry/clear pulses        |
// |          lock_level            chamber level from the water datapath     |
// |          fill/drain            one level step per cycle                  |
// |          outer_open/inner_open port commands                             |
// |          grant_outer/_inner    entry permission for the served side      |
// |          busy                  high outside IDLE                         |
// |          abort                 1-cycle pulse on an entry/exit timeout    |
// | Config : LOCK_SCHED_TIMEOUT_EN enables the ENTER/EXIT wait limit;        |
// |          without it those states wait forever and abort is tied low.     |
// | Rev    : 1.0  initial release                                            |
// ============================================================================
`default_nettype none

module lock_scheduler
   import lock_scheduler_pkg::*;
#(
   parameter int                 LEVEL_W     = 8,
   parameter logic [LEVEL_W-1:0] OUTER_LEVEL = LEVEL_W'(DEF_OUTER_LEVEL),
   parameter logic [LEVEL_W-1:0] INNER_LEVEL = LEVEL_W'(DEF_INNER_LEVEL),
   parameter int                 GATE_CYCLES = 4,
   parameter int                 TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_outer,
   input  logic               req_inner,
   input  logic               gondola_in,
   input  logic               gondola_out,
   input  logic [LEVEL_W-1:0] lock_level,
   output logic               fill,
   output logic               drain,
   output logic               outer_open,
   output logic               inner_open,
   output logic               grant_outer,
   output logic               grant_inner,
   output logic               busy,
   output logic               abort
);

   // One counter serves port travel and the optional wait limit, so it is
   // sized for whichever is longer.
   localparam int CNT_MAX = max_int(GATE_CYCLES, TIMEOUT_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES - 1);
`ifdef LOCK_SCHED_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);
`endif

   state_t state, state_n;
   logic   side;          // served (entry) side of the current passage
   logic   last_served;
   logic   pick_side;
   logic   skip_out;      // ENTER timed out: return to IDLE after closing

   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic               tmr_done;

   logic               entry_open;
   logic               exit_open;
   logic               grant;
   logic               abort_c;
   logic [LEVEL_W-1:0] entry_lvl;
   logic [LEVEL_W-1:0] exit_lvl;
   logic [LEVEL_W-1:0] target;

   gate_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Alternate on a tie so neither side can starve the other.
   assign pick_side = (req_outer & req_inner) ? ~last_served
                    : (req_outer ? SIDE_OUTER : SIDE_INNER);

   assign entry_lvl = (side == SIDE_OUTER) ? OUTER_LEVEL : INNER_LEVEL;
   assign exit_lvl  = (side == SIDE_OUTER) ? INNER_LEVEL : OUTER_LEVEL;
   assign target    = (state == ST_EQ_OUT) ? exit_lvl : entry_lvl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         side        <= SIDE_INNER;
         last_served <= SIDE_INNER;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && (req_outer | req_inner)) begin
            side <= pick_side;
         end
         if (state != ST_IDLE && state_n == ST_IDLE) begin
            last_served <= side;
         end
      end
   end

`ifdef LOCK_SCHED_TIMEOUT_EN
   logic aborted;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aborted <= 1'b0;
      end else if (state_n == ST_IDLE) begin
         aborted <= 1'b0;
      end else if (abort_c && state == ST_ENTER) begin
         aborted <= 1'b1;
      end
   end

   assign skip_out = aborted;
`else
   assign skip_out = 1'b0;
`endif

   always_comb begin
      state_n    = state;
      fill       = 1'b0;
      drain      = 1'b0;
      entry_open = 1'b0;
      exit_open  = 1'b0;
      grant      = 1'b0;
      abort_c    = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = GATE_LOAD;
      busy       = (state != ST_IDLE);

      case (state)
         ST_IDLE: begin
            if (req_outer | req_inner) state_n = ST_EQ_IN;
         end

         // An unreachable target simply keeps the FSM here.
         ST_EQ_IN, ST_EQ_OUT: begin
            if (lock_level < target) begin
               fill = 1'b1;
            end else if (lock_level > target) begin
               drain = 1'b1;
            end else begin
               state_n  = (state == ST_EQ_IN) ? ST_OPEN_IN : ST_OPEN_OUT;
               tmr_load = 1'b1;
            end
         end

         ST_OPEN_IN: begin
            entry_open = 1'b1;
            if (tmr_done) begin
               state_n = ST_ENTER;
`ifdef LOCK_SCHED_TIMEOUT_EN
               tmr_load = 1'b1;
               tmr_val  = TMO_LOAD;
`endif
            end
         end

         ST_ENTER: begin
            entry_open = 1'b1;
            grant      = 1'b1;
            if (gondola_in) begin
               state_n  = ST_CLOSE_IN;
               tmr_load = 1'b1;
            end
`ifdef LOCK_SCHED_TIMEOUT_EN
            else if (tmr_done) begin
               abort_c  = 1'b1;
               state_n  = ST_CLOSE_IN;
               tmr_load = 1'b1;
            end
`endif
         end

         ST_CLOSE_IN: begin
            if (tmr_done) state_n = skip_out ? ST_IDLE : ST_EQ_OUT;
         end

         ST_OPEN_OUT: begin
            exit_open = 1'b1;
            if (tmr_done) begin
               state_n = ST_EXIT;
`ifdef LOCK_SCHED_TIMEOUT_EN
               tmr_load = 1'b1;
               tmr_val  = TMO_LOAD;
`endif
            end
         end

         ST_EXIT: begin
            exit_open = 1'b1;
            if (gondola_out) begin
               state_n  = ST_CLOSE_OUT;
               tmr_load = 1'b1;
            end
`ifdef LOCK_SCHED_TIMEOUT_EN
            else if (tmr_done) begin
               abort_c  = 1'b1;
               state_n  = ST_CLOSE_OUT;
               tmr_load = 1'b1;
            end
`endif
         end

         ST_CLOSE_OUT: begin
            if (tmr_done) state_n = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Entry and exit are always opposite sides and are open in disjoint
   // states, so the two port commands can never be high together.
   assign outer_open  = (entry_open & (side == SIDE_OUTER)) |
                        (exit_open  & (side == SIDE_INNER));
   assign inner_open  = (entry_open & (side == SIDE_INNER)) |
                        (exit_open  & (side == SIDE_OUTER));
   assign grant_outer = grant & (side == SIDE_OUTER);
   assign grant_inner = grant & (side == SIDE_INNER);
   assign abort       = abort_c;

endmodule

`default_nettype wire

// File: tb/tb_lock_scheduler.sv
// ============================================================================
// | Module : tb_lock_scheduler                                               |
// | Brief  : Self-checking bench for lock_scheduler. Each passage is turned  |
// |          into a per-cycle list of stimulus and expected outputs built    |
// |          from level differences and gate/wait durations; a small water   |
// |          datapath follows fill/drain. Table vectors, random passages,    |
// |          reset during EQ_OUT, and the optional timeout are covered.      |
// | Config : LOCK_SCHED_TIMEOUT_EN adds the entry-timeout scenario.          |
// | Rev    : 1.0  initial release                                            |
// ============================================================================
`default_nettype none

module tb_lock_scheduler;

   localparam int G  = 4;
   localparam int T  = 64;
   localparam int OL = 80;
   localparam int IL = 30;

   // Expected-output bit positions
   localparam bit [7:0] F  = 8'h01, D  = 8'h02, OO = 8'h04, IO = 8'h08;
   localparam bit [7:0] GO = 8'h10, GI = 8'h20, B  = 8'h40, A  = 8'h80;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_outer, req_inner, gondola_in, gondola_out;
   logic [7:0] lvl;
   logic       fill, drain, outer_open, inner_open;
   logic       grant_outer, grant_inner, busy, abort;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit       ro, ri, gin, gout;
      bit [7:0] out;
   } cyc_t;

   typedef struct {
      bit ro, ri;
      int lvl0, kin, kout;
      bit exp_inner;
   } vec_t;

   cyc_t tr[$];
   bit   model_last;   // 1 = inner side served last

   lock_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .req_outer   (req_outer),
      .req_inner   (req_inner),
      .gondola_in  (gondola_in),
      .gondola_out (gondola_out),
      .lock_level  (lvl),
      .fill        (fill),
      .drain       (drain),
      .outer_open  (outer_open),
      .inner_open  (inner_open),
      .grant_outer (grant_outer),
      .grant_inner (grant_inner),
      .busy        (busy),
      .abort       (abort)
   );

   always #5 clk = ~clk;

   // Water datapath: one level step per cycle in the commanded direction.
   always @(posedge clk) begin
      if (!reset) begin
         if (fill)       lvl <= lvl + 8'd1;
         else if (drain) lvl <= lvl - 8'd1;
      end
   end

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic bit [7:0] actual();
      return {abort, busy, grant_inner, grant_outer, inner_open, outer_open, drain, fill};
   endfunction

   task automatic push(input int n, input bit [7:0] o);
      for (int i = 0; i < n; i++) begin
         cyc_t c;
         c.ro = 1'b0; c.ri = 1'b0; c.gin = 1'b0; c.gout = 1'b0; c.out = o;
         tr.push_back(c);
      end
   endtask

   // Expected cycle list for one passage served on side s (1 = inner).
   task automatic build(input bit s, input bit ro, input bit ri, input int l0,
                        input int kin, input int kout, input bit tmo);
      int tin, tout, d;
      bit [7:0] eo, xo, gr;
      tin  = s ? IL : OL;
      tout = s ? OL : IL;
      eo   = s ? IO : OO;
      xo   = s ? OO : IO;
      gr   = s ? GI : GO;
      tr.delete();
      push(1, 8'h00);
      d = tin - l0;
      push(iabs(d), B | ((d > 0) ? F : D));
      push(1, B);
      push(G, B | eo);
      if (tmo) begin
         push(T, B | eo | gr);
         tr[tr.size()-1].out = tr[tr.size()-1].out | A;
         push(G, B);
      end else begin
         push(kin + 1, B | eo | gr);
         tr[tr.size()-1].gin = 1'b1;
         push(G, B);
         d = tout - tin;
         push(iabs(d), B | ((d > 0) ? F : D));
         push(1, B);
         push(G, B | xo);
         push(kout + 1, B | xo);
         tr[tr.size()-1].gout = 1'b1;
         push(G, B);
      end
      push(1, 8'h00);
      // Requester holds its request until the first granted cycle.
      for (int i = 0; i < tr.size(); i++) begin
         tr[i].ro = ro;
         tr[i].ri = ri;
         if ((tr[i].out & (GO | GI)) != 8'h00) break;
      end
   endtask

   task automatic run(input int upto, input string nm);
      int n;
      bit [7:0] act;
      n = (upto < tr.size()) ? upto : tr.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req_outer   = tr[i].ro;
         req_inner   = tr[i].ri;
         gondola_in  = tr[i].gin;
         gondola_out = tr[i].gout;
         #1;
         act = actual();
         checks++;
         if (act !== tr[i].out) begin
            errors++;
            $display("FAIL %s cycle %0d: outputs got %b expected %b (abt,bsy,gi,go,io,oo,dr,fl)",
                     nm, i, act, tr[i].out);
         end
         if (outer_open === 1'b1 && inner_open === 1'b1) begin
            errors++;
            $display("FAIL %s cycle %0d: both ports open", nm, i);
         end
      end
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      req_outer = 1'b0; req_inner = 1'b0; gondola_in = 1'b0; gondola_out = 1'b0;
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if (actual() !== 8'h00) begin
         errors++;
         $display("FAIL %s: outputs got %b expected 00000000", nm, actual());
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      bit   s, ro, ri;
      int   p;

      vt[0] = '{1'b1, 1'b0, 30,  2, 1, 1'b0};
      vt[1] = '{1'b0, 1'b1, 30,  0, 3, 1'b1};
      vt[2] = '{1'b1, 1'b1, 30,  1, 1, 1'b0};
      vt[3] = '{1'b1, 1'b1, 80,  0, 0, 1'b1};
      vt[4] = '{1'b0, 1'b1, 200, 4, 0, 1'b1};
      vt[5] = '{1'b1, 1'b0, 80,  0, 2, 1'b0};

      reset = 1'b1;
      req_outer = 1'b0; req_inner = 1'b0; gondola_in = 1'b0; gondola_out = 1'b0;
      lvl = 8'd0;
      model_last = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      reset = 1'b0;

      // Table vectors: served side taken from the table.
      for (int v = 0; v < 6; v++) begin
         lvl = vt[v].lvl0[7:0];
         build(vt[v].exp_inner, vt[v].ro, vt[v].ri, vt[v].lvl0, vt[v].kin, vt[v].kout, 1'b0);
         run(tr.size(), $sformatf("table%0d", v));
         idle_inputs();
         model_last = vt[v].exp_inner;
      end

      // Random passages: served side from the arbitration rule.
      for (int n = 0; n < 12; n++) begin
         p  = $urandom_range(1, 3);
         ro = p[0];
         ri = p[1];
         s  = (ro & ri) ? ~model_last : ri;
         lvl = 8'($urandom_range(0, 150));
         build(s, ro, ri, int'(lvl), $urandom_range(0, 6), $urandom_range(0, 6), 1'b0);
         run(tr.size(), $sformatf("rand%0d", n));
         idle_inputs();
         model_last = s;
      end

      // Reset while draining in EQ_OUT (outer -> inner, starting at 80).
      lvl = 8'd80;
      build(1'b0, 1'b1, 1'b0, 80, 0, 0, 1'b0);
      run(15, "pre_reset");
      idle_inputs();
      #2 reset = 1'b1;
      #1 check_zero("reset_in_eq_out");
      repeat (2) @(negedge clk);
      check_zero("reset_held");
      reset = 1'b0;
      model_last = 1'b1;

      // After reset a tie goes outer, then the next tie goes inner.
      build(1'b0, 1'b1, 1'b1, int'(lvl), 1, 1, 1'b0);
      run(tr.size(), "post_reset_tie1");
      idle_inputs();
      build(1'b1, 1'b1, 1'b1, int'(lvl), 0, 0, 1'b0);
      run(tr.size(), "post_reset_tie2");
      idle_inputs();

`ifdef LOCK_SCHED_TIMEOUT_EN
      lvl = 8'd80;
      build(1'b0, 1'b1, 1'b0, 80, 0, 0, 1'b1);
      run(tr.size(), "timeout");
      idle_inputs();
      // last_served is now outer, so a tie must go inner.
      build(1'b1, 1'b1, 1'b1, int'(lvl), 0, 0, 1'b0);
      run(tr.size(), "after_timeout");
      idle_inputs();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
